// File: rtl/serial_add44_pkg.sv
// Shared types and constants for the bit-serial
// reconstructing adder.
package serial_add44_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int W_DEF = 4;
  localparam int CNT_W = $clog2(W_DEF);

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder used by the
// serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add44.sv
// Bit-serial reconstructing adder: A = D[W-1:0] + B,
// LSB first, with a carry-vs-borrow consistency flag.
module serial_add44
  import serial_add44_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [W:0]   D,
  input  logic [W-1:0] B,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] A,
  output logic         OK
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t         state;
  logic [W-1:0]   d_sr;
  logic [W-1:0]   b_sr;
  logic [W-1:0]   a_sr;
  logic           carry;
  logic           brw;
  logic [CW-1:0]  cnt;
  logic           sum;
  logic           cout;

  full_adder u_fa (
    .a    (d_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (sum),
    .cout (cout)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      d_sr  <= '0;
      b_sr  <= '0;
      a_sr  <= '0;
      carry <= 1'b0;
      brw   <= 1'b0;
      cnt   <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      OK    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            d_sr  <= D[W-1:0];
            b_sr  <= B;
            brw   <= D[W];
            carry <= 1'b0;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr  <= {sum, a_sr[W-1:1]};
          d_sr  <= d_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= cout;
          cnt   <= cnt + 1'b1;
          // last bit: carry-out decides consistency
          if (cnt == CW'(W - 1)) begin
            DONE  <= 1'b1;
            OK    <= (cout == brw);
            state <= FIN;
          end
        end
        FIN: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign A = a_sr;

endmodule
